// File: rtl/cart_bank_ctrl_if.sv
// Bus bundle between the 6507 bus controller and the cartridge bank controller.
// The master drives CPU address/data and ROM data; the slave drives cartridge outputs.
interface cart_bank_ctrl_if #(
  parameter int unsigned ROM_AW = 15
);
  logic [1:0]        CART_MODE;
  logic [12:0]       CPU_Addr;
  logic [7:0]        CPU_Dout;
  logic              CPU_R_W_n;
  logic [7:0]        ROM_Dout;
  logic              CART_CS;
  logic [ROM_AW-1:0] CART_Addr;
  logic [7:0]        CART_Dout;
  logic [2:0]        BANK;
  logic              BANK_HIT;

  modport master (
    output CART_MODE, CPU_Addr, CPU_Dout, CPU_R_W_n, ROM_Dout,
    input  CART_CS, CART_Addr, CART_Dout, BANK, BANK_HIT
  );

  modport slave (
    input  CART_MODE, CPU_Addr, CPU_Dout, CPU_R_W_n, ROM_Dout,
    output CART_CS, CART_Addr, CART_Dout, BANK, BANK_HIT
  );
endinterface

// File: rtl/cart_bank_ctrl.sv
// Atari F8/F6/F4 cartridge bank-switching controller for the 6507 4K cartridge window.
// Optional 128-byte SuperChip RAM is compiled in when SUPERCHIP_EN is defined.
module cart_bank_ctrl #(
  parameter logic [2:0]  RESET_BANK = 3'd7,
  parameter int unsigned ROM_AW     = 15
) (
  input logic              CLOCKBUS,
  input logic              RES_n,
  cart_bank_ctrl_if.slave  bus
);

  localparam logic [0:0] StInit = 1'b0;
  localparam logic [0:0] StRun  = 1'b1;

  logic [0:0]  state_q, state_d;
  logic [2:0]  bank_q, bank_d;
  logic [12:0] prev_addr_q;
  logic        hit_q, hit_d;
  logic [1:0]  mode_q;

  logic [2:0]        bank_mask;
  logic [2:0]        bank_eff;
  logic [12:0]       hot_lo, hot_hi;
  logic              hot_match;
  logic              trigger;
  logic [2:0]        hot_bank;
  logic [ROM_AW-1:0] cart_addr;

  // Mode is captured only on the INIT->RUN edge and deliberately not reset.
  always_ff @(posedge CLOCKBUS) begin
    if (state_q == StInit) begin
      mode_q <= bus.CART_MODE;
    end
  end

  always_comb begin
    bank_mask = 3'b000;
    hot_lo    = 13'h0001;
    hot_hi    = 13'h0000;
    unique case (mode_q)
      2'b01: begin
        bank_mask = 3'b001;
        hot_lo    = 13'h1FF8;
        hot_hi    = 13'h1FF9;
      end
      2'b10: begin
        bank_mask = 3'b011;
        hot_lo    = 13'h1FF6;
        hot_hi    = 13'h1FF9;
      end
      2'b11: begin
        bank_mask = 3'b111;
        hot_lo    = 13'h1FF4;
        hot_hi    = 13'h1FFB;
      end
      default: ;
    endcase
    if (state_q == StInit) begin
      bank_mask = 3'b000;
    end
  end

  assign hot_match = (state_q == StRun) && (bus.CPU_Addr >= hot_lo) && (bus.CPU_Addr <= hot_hi);
  assign trigger   = hot_match && (bus.CPU_Addr != prev_addr_q);
  // Windows span at most 8 addresses, so the low three bits give the offset modulo 8.
  assign hot_bank  = bus.CPU_Addr[2:0] - hot_lo[2:0];

  always_comb begin
    state_d = StRun;
    bank_d  = bank_q;
    hit_d   = 1'b0;
    if (trigger) begin
      bank_d = hot_bank;
      hit_d  = 1'b1;
    end
  end

  always_ff @(posedge CLOCKBUS or negedge RES_n) begin
    if (!RES_n) begin
      state_q     <= StInit;
      bank_q      <= RESET_BANK;
      prev_addr_q <= 13'h0000;
      hit_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      bank_q      <= bank_d;
      prev_addr_q <= bus.CPU_Addr;
      hit_q       <= hit_d;
    end
  end

  assign bank_eff = bank_q & bank_mask;

  always_comb begin
    cart_addr       = '0;
    cart_addr[14:0] = {bank_eff, bus.CPU_Addr[11:0]};
  end

  assign bus.CART_CS   = bus.CPU_Addr[12];
  assign bus.CART_Addr = cart_addr;
  assign bus.BANK      = bank_eff;
  assign bus.BANK_HIT  = hit_q;

`ifdef SUPERCHIP_EN
  logic [7:0] ram_q [128];
  logic       ram_wr;
  logic       ram_rd;

  assign ram_wr = (bus.CPU_Addr[12:7] == 6'b100000) && !bus.CPU_R_W_n;
  assign ram_rd = (bus.CPU_Addr[12:7] == 6'b100001);

  always_ff @(posedge CLOCKBUS) begin
    if (ram_wr) begin
      ram_q[bus.CPU_Addr[6:0]] <= bus.CPU_Dout;
    end
  end

  assign bus.CART_Dout = ram_rd ? ram_q[bus.CPU_Addr[6:0]] : bus.ROM_Dout;
`else
  logic unused_bus_bits;
  assign unused_bus_bits = ^{bus.CPU_Dout, bus.CPU_R_W_n};
  assign bus.CART_Dout   = bus.ROM_Dout;
`endif

endmodule

// File: tb/tb_cart_bank_ctrl.sv
// Self-checking bench for cart_bank_ctrl: directed scenarios plus randomized traffic
// against a behavioural model of the hotspot banking rules.
module tb_cart_bank_ctrl;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  cart_bank_ctrl_if #(.ROM_AW(15)) bus ();

  cart_bank_ctrl #(
    .RESET_BANK (3'd7),
    .ROM_AW     (15)
  ) dut (
    .CLOCKBUS (clk),
    .RES_n    (rst_n),
    .bus      (bus)
  );

  int errs = 0;
  int checks = 0;

  // Behavioural model state
  bit          m_run;
  logic [1:0]  m_mode;
  logic [2:0]  m_bank;
  logic [12:0] m_prev;
  bit          m_hit;
  logic [7:0]  m_ram [128];
  bit          m_ram_v [128];

  function automatic int banks_of(logic [1:0] mode);
    return (mode == 2'b00) ? 1 : (1 << mode);
  endfunction

  function automatic int hot_base(logic [1:0] mode);
    case (mode)
      2'b01:   return 'h1FF8;
      2'b10:   return 'h1FF6;
      2'b11:   return 'h1FF4;
      default: return 0;
    endcase
  endfunction

  function automatic logic [2:0] exp_bank();
    logic [2:0] mask;
    mask = 3'(banks_of(m_mode) - 1);
    return m_run ? (m_bank & mask) : 3'd0;
  endfunction

  function automatic logic [14:0] exp_addr(logic [12:0] a);
    return {exp_bank(), a[11:0]};
  endfunction

  // Returns 1 when the expected read data is known.
  function automatic bit exp_dout(logic [12:0] a, logic [7:0] rom, output logic [7:0] d);
    d = rom;
`ifdef SUPERCHIP_EN
    if (a[12:7] == 6'b100001) begin
      if (!m_ram_v[a[6:0]]) return 1'b0;
      d = m_ram[a[6:0]];
    end
`endif
    return 1'b1;
  endfunction

  task automatic model_reset();
    m_run  = 1'b0;
    m_bank = 3'd7;
    m_prev = 13'h0000;
    m_hit  = 1'b0;
  endtask

  task automatic model_step();
    int off;
    if (!m_run) begin
      m_run  = 1'b1;
      m_mode = bus.CART_MODE;
      m_hit  = 1'b0;
    end else begin
      off = int'(bus.CPU_Addr) - hot_base(m_mode);
      if (m_mode != 2'b00 && off >= 0 && off < banks_of(m_mode) && bus.CPU_Addr != m_prev) begin
        m_bank = off[2:0];
        m_hit  = 1'b1;
      end else begin
        m_hit = 1'b0;
      end
    end
    m_prev = bus.CPU_Addr;
`ifdef SUPERCHIP_EN
    if (!bus.CPU_R_W_n && bus.CPU_Addr[12:7] == 6'b100000) begin
      m_ram[bus.CPU_Addr[6:0]]   = bus.CPU_Dout;
      m_ram_v[bus.CPU_Addr[6:0]] = 1'b1;
    end
`endif
  endtask

  task automatic tick();
    model_step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(logic [12:0] a, logic rw, logic [7:0] d, logic [7:0] rom);
    bus.CPU_Addr  = a;
    bus.CPU_R_W_n = rw;
    bus.CPU_Dout  = d;
    bus.ROM_Dout  = rom;
    #2;
  endtask

  // Leaves the DUT in INIT with reset released, at a falling edge.
  task automatic do_reset(logic [1:0] mode);
    rst_n         = 1'b0;
    bus.CART_MODE = mode;
    bus.CPU_Addr  = 13'h0000;
    bus.CPU_R_W_n = 1'b1;
    model_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    rst_n         = 1'b0;
    bus.CART_MODE = 2'b01;
    model_reset();
    drive(13'h1000, 1'b1, 8'h00, 8'h00);
    @(posedge clk);
    #2;
    checks++;
    if (bus.BANK !== 3'd0 || bus.BANK_HIT !== 1'b0) begin
      errs++;
      $display("FAIL reset_init: BANK=%0d HIT=%0b, want 0/0", bus.BANK, bus.BANK_HIT);
    end
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    checks++;
    if (bus.BANK !== 3'd0) begin
      errs++;
      $display("FAIL init_released: BANK=%0d, want 0", bus.BANK);
    end
    tick();
    #2;
    checks++;
    if (bus.BANK !== 3'd1 || bus.CART_Addr !== 15'h1000 || bus.BANK_HIT !== 1'b0
        || bus.CART_CS !== 1'b1) begin
      errs++;
      $display("FAIL reset_run: BANK=%0d ADDR=%h HIT=%0b CS=%0b, want 1/1000/0/1",
               bus.BANK, bus.CART_Addr, bus.BANK_HIT, bus.CART_CS);
    end
  endtask

  task automatic test_f6_switch();
    do_reset(2'b10);
    tick();
    drive(13'h1FF6, 1'b1, 8'h00, 8'h00);
    checks++;
    if (bus.CART_Addr !== 15'h3FF6 || bus.BANK_HIT !== 1'b0) begin
      errs++;
      $display("FAIL f6_hot_cycle: ADDR=%h HIT=%0b, want 3ff6/0", bus.CART_Addr, bus.BANK_HIT);
    end
    tick();
    drive(13'h1000, 1'b1, 8'h00, 8'h00);
    checks++;
    if (bus.CART_Addr !== 15'h0000 || bus.BANK !== 3'd0 || bus.BANK_HIT !== 1'b1) begin
      errs++;
      $display("FAIL f6_next: ADDR=%h BANK=%0d HIT=%0b, want 0000/0/1",
               bus.CART_Addr, bus.BANK, bus.BANK_HIT);
    end
    tick();
    drive(13'h1001, 1'b1, 8'h00, 8'h00);
    checks++;
    if (bus.BANK_HIT !== 1'b0 || bus.BANK !== 3'd0) begin
      errs++;
      $display("FAIL f6_pulse_end: HIT=%0b BANK=%0d, want 0/0", bus.BANK_HIT, bus.BANK);
    end
  endtask

  task automatic test_f4_stall();
    logic [12:0] seq_a [5];
    logic [2:0]  seq_bank [5];
    logic        seq_hit [5];
    int          hits;
    seq_a    = '{13'h1FF5, 13'h1FF5, 13'h1FF5, 13'h1FFB, 13'h1123};
    seq_bank = '{3'd7, 3'd1, 3'd1, 3'd1, 3'd7};
    seq_hit  = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
    hits = 0;
    do_reset(2'b11);
    tick();
    for (int i = 0; i < 5; i++) begin
      drive(seq_a[i], 1'b1, 8'h00, 8'h00);
      hits += int'(bus.BANK_HIT);
      checks++;
      if (bus.BANK !== seq_bank[i] || bus.BANK_HIT !== seq_hit[i]) begin
        errs++;
        $display("FAIL f4_stall[%0d]: BANK=%0d HIT=%0b, want %0d/%0b",
                 i, bus.BANK, bus.BANK_HIT, seq_bank[i], seq_hit[i]);
      end
      if (i < 4) tick();
    end
    checks++;
    if (bus.CART_Addr !== 15'h7123 || hits != 2) begin
      errs++;
      $display("FAIL f4_final: ADDR=%h hits=%0d, want 7123/2", bus.CART_Addr, hits);
    end
    tick();
  endtask

  task automatic test_mode00();
    do_reset(2'b00);
    tick();
    drive(13'h1FF8, 1'b1, 8'h00, 8'h00);
    checks++;
    if (bus.BANK !== 3'd0 || bus.CART_Addr !== 15'h0FF8) begin
      errs++;
      $display("FAIL m00_addr: BANK=%0d ADDR=%h, want 0/0ff8", bus.BANK, bus.CART_Addr);
    end
    bus.CART_MODE = 2'b11;
    tick();
    drive(13'h1FF5, 1'b1, 8'h00, 8'h00);
    tick();
    drive(13'h1FFB, 1'b1, 8'h00, 8'h00);
    checks++;
    if (bus.BANK_HIT !== 1'b0 || bus.BANK !== 3'd0 || bus.CART_Addr !== 15'h0FFB) begin
      errs++;
      $display("FAIL m00_nochange: HIT=%0b BANK=%0d ADDR=%h, want 0/0/0ffb",
               bus.BANK_HIT, bus.BANK, bus.CART_Addr);
    end
    tick();
  endtask

  task automatic test_reset_mid();
    do_reset(2'b01);
    tick();
    drive(13'h1FF8, 1'b1, 8'h00, 8'h00);
    tick();
    drive(13'h1000, 1'b1, 8'h00, 8'h00);
    checks++;
    if (bus.BANK !== 3'd0 || bus.BANK_HIT !== 1'b1) begin
      errs++;
      $display("FAIL mid_pre: BANK=%0d HIT=%0b, want 0/1", bus.BANK, bus.BANK_HIT);
    end
    #2;
    rst_n = 1'b0;
    model_reset();
    #1;
    checks++;
    if (bus.BANK !== 3'd0 || bus.BANK_HIT !== 1'b0 || bus.CART_Addr !== 15'h0000) begin
      errs++;
      $display("FAIL mid_async: BANK=%0d HIT=%0b ADDR=%h, want 0/0/0000",
               bus.BANK, bus.BANK_HIT, bus.CART_Addr);
    end
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    #2;
    checks++;
    if (bus.BANK !== 3'd1 || bus.BANK_HIT !== 1'b0) begin
      errs++;
      $display("FAIL mid_release: BANK=%0d HIT=%0b, want 1/0", bus.BANK, bus.BANK_HIT);
    end
  endtask

  task automatic test_superchip();
    logic [7:0] want;
`ifdef SUPERCHIP_EN
    want = 8'hA5;
`else
    want = 8'h3C;
`endif
    do_reset(2'b01);
    tick();
    drive(13'h1005, 1'b0, 8'hA5, 8'h11);
    tick();
    drive(13'h1085, 1'b1, 8'h00, 8'h3C);
    checks++;
    if (bus.CART_Dout !== want) begin
      errs++;
      $display("FAIL superchip_rd: DOUT=%h, want %h", bus.CART_Dout, want);
    end
    tick();
  endtask

  task automatic test_random();
    logic [12:0] a;
    logic [7:0]  d;
    for (int mode = 0; mode < 4; mode++) begin
      do_reset(2'(mode));
      tick();
      a = 13'h0000;
      for (int n = 0; n < 250; n++) begin
        case ($urandom_range(0, 3))
          0: a = 13'h1FF0 + 13'($urandom_range(0, 15));
          1: ;
          2: a = 13'($urandom);
          default: a = 13'h1000 + 13'($urandom_range(0, 255));
        endcase
        if ($urandom_range(0, 19) == 0) bus.CART_MODE = 2'($urandom);
        drive(a, 1'($urandom), 8'($urandom), 8'($urandom));
        checks++;
        if (bus.BANK !== exp_bank() || bus.CART_Addr !== exp_addr(a)
            || bus.BANK_HIT !== m_hit || bus.CART_CS !== a[12]) begin
          errs++;
          $display("FAIL rand_m%0d_c%0d: A=%h BANK=%0d ADDR=%h HIT=%0b, want %0d/%h/%0b",
                   mode, n, a, bus.BANK, bus.CART_Addr, bus.BANK_HIT,
                   exp_bank(), exp_addr(a), m_hit);
        end
        if (exp_dout(a, bus.ROM_Dout, d)) begin
          checks++;
          if (bus.CART_Dout !== d) begin
            errs++;
            $display("FAIL rand_dout_m%0d_c%0d: A=%h DOUT=%h, want %h",
                     mode, n, a, bus.CART_Dout, d);
          end
        end
        tick();
      end
    end
  endtask

  initial begin
    for (int i = 0; i < 128; i++) m_ram_v[i] = 1'b0;
    bus.CART_MODE = 2'b00;
    bus.CPU_Addr  = 13'h0000;
    bus.CPU_Dout  = 8'h00;
    bus.CPU_R_W_n = 1'b1;
    bus.ROM_Dout  = 8'h00;
    test_reset();
    test_f6_switch();
    test_f4_stall();
    test_mode00();
    test_reset_mid();
    test_superchip();
    test_random();
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
